// File: rtl/sprite_scan_renderer.sv
// rtl/sprite_scan_renderer.sv - 32x32 one-bit sprite row fetch and per-pixel shifter for the VGA output stage
//
// Purpose: fetches the sprite ROM row for the next line during horizontal
// blank, then shifts it out one bit per pixel strobe starting at the sprite X.
// Sprite position updates are handshaken into a pending register and only
// become active at frame_start, so a sprite never tears mid-frame.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_en                pixel strobe; hcount/vcount advance when high
//   hcount, vcount        beam position from the timing generator
//   frame_start           one-cycle pulse at the start of line 0
//   pos_valid/pos_ready   position offer handshake; pos_x/pos_y = top-left
//   addRom / dataRom      registered ROM row address / combinational row data
//   mirror                (SPRITE_MIRROR_EN only) 1 = draw row LSB-first
//   pixel_on              registered sprite pixel for the current column
//   busy                  FSM not idle
//
// Build option: define SPRITE_MIRROR_EN to add the mirror input.

module sprite_scan_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int COORD_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               frame_start,
    input  logic               pos_valid,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
`ifdef SPRITE_MIRROR_EN
    input  logic               mirror,
`endif
    output logic               pos_ready,
    output logic [4:0]         addRom,
    input  logic [31:0]        dataRom,
    output logic               pixel_on,
    output logic               busy
);

    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W:0]   V_TOT  = (COORD_W + 1)'(V_TOTAL);
    // A geometry with more visible than total lines, or a visible width that
    // does not fit the coordinate width, can never render; disable hits.
    localparam bit GEOM_OK = (V_ACTIVE <= V_TOTAL) && (H_ACTIVE < (1 << COORD_W));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_X,
        S_DRAW
    } state_t;

    // ---------------- position registers ----------------
    logic               pend_full_q, pend_full_d;
    logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic               accept;

    assign pos_ready = ~pend_full_q;
    assign accept    = pos_valid & ~pend_full_q;

    always_comb begin
        pend_full_d = pend_full_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        if (frame_start && pend_full_q) begin
            act_x_d     = pend_x_q;
            act_y_d     = pend_y_q;
            pend_full_d = 1'b0;
        end
        // A handshake in the same cycle as a commit refills the pending slot.
        if (accept) begin
            pend_x_d    = pos_x;
            pend_y_d    = pos_y;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
        end
    end

    // ---------------- next-line row hit ----------------
    logic [COORD_W-1:0] nxt;
    logic [COORD_W:0]   row_off;
    logic               row_hit;
    logic               fetch_go;

    // A sprite placed near the bottom of the frame continues onto the top
    // lines after vcount wraps, so the row offset is taken modulo V_TOTAL.
    // Lines above the sprite still land far outside 0..31 and miss.
    always_comb begin
        nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        if (nxt < act_y_q) begin
            row_off = {1'b0, nxt} + V_TOT - {1'b0, act_y_q};
        end else begin
            row_off = {1'b0, nxt} - {1'b0, act_y_q};
        end
    end

    assign row_hit  = GEOM_OK && (row_off[COORD_W:5] == '0);
    assign fetch_go = pix_en && (hcount == H_ACT) && row_hit;

    // ---------------- fetch / draw FSM ----------------
    state_t      state_q;
    logic [4:0]  addr_q;
    logic [31:0] shreg_q;
    logic [5:0]  cnt_q;
    logic        pixel_q;
    logic        out_bit;
    logic [31:0] shreg_shift;

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;
    assign out_bit     = mirror_q ? shreg_q[0] : shreg_q[31];
    assign shreg_shift = mirror_q ? {1'b0, shreg_q[31:1]} : {shreg_q[30:0], 1'b0};
`else
    assign out_bit     = shreg_q[31];
    assign shreg_shift = {shreg_q[30:0], 1'b0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            pixel_q <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_go) begin
                        addr_q  <= row_off[4:0];
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    shreg_q <= dataRom;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
`ifdef SPRITE_MIRROR_EN
                    mirror_q <= mirror;
`endif
                    if (pix_en && hcount == '0) begin
                        // The hcount==0 strobe is consumed here, so a sprite
                        // at X=0 must start drawing on this same strobe.
                        if (act_x_q == '0) begin
                            pixel_q <= out_bit;
                            shreg_q <= shreg_shift;
                            cnt_q   <= 6'd1;
                            state_q <= S_DRAW;
                        end else begin
                            state_q <= S_WAIT_X;
                        end
                    end
                end
                S_WAIT_X: begin
                    if (pix_en) begin
                        if (hcount == H_ACT) begin
                            // Off-screen X: give up, but still take this
                            // blank's fetch for the following line.
                            addr_q  <= row_off[4:0];
                            state_q <= fetch_go ? S_FETCH : S_IDLE;
                        end else if (hcount == act_x_q) begin
                            pixel_q <= out_bit;
                            shreg_q <= shreg_shift;
                            cnt_q   <= 6'd1;
                            state_q <= S_DRAW;
                        end
                    end
                end
                S_DRAW: begin
                    if (pix_en) begin
                        if (hcount >= H_ACT || cnt_q == 6'd32) begin
                            pixel_q <= 1'b0;
                            if (fetch_go) begin
                                addr_q <= row_off[4:0];
                            end
                            state_q <= fetch_go ? S_FETCH : S_IDLE;
                        end else begin
                            pixel_q <= out_bit;
                            shreg_q <= shreg_shift;
                            cnt_q   <= cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pixel_q <= 1'b0;
                end
            endcase
        end
    end

    assign addRom   = addr_q;
    assign pixel_on = pixel_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_scan_renderer.sv
// tb/tb_sprite_scan_renderer.sv - directed table-driven bench for sprite_scan_renderer
module tb_sprite_scan_renderer;

    localparam int H_TOTAL = 800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        pos_valid = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        pos_ready;
    logic        pixel_on;
    logic        busy;
    logic [4:0]  addRom;
    logic [31:0] dataRom;
    logic [31:0] rom [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign dataRom = rom[addRom];

    sprite_scan_renderer #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .V_TOTAL (525),
        .COORD_W (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_start(frame_start),
        .pos_valid  (pos_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_ready  (pos_ready),
        .addRom     (addRom),
        .dataRom    (dataRom),
        .pixel_on   (pixel_on),
        .busy       (busy)
    );

    typedef struct {
        int          x;
        int          y;
        int          line;
        logic [31:0] pat;
        int          div;
        int          exp_fetch;
        int          exp_addr;
        int          exp_first;
        int          exp_last;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        pix_en = 1'b0; frame_start = 1'b0; pos_valid = 1'b0;
        hcount = '0; vcount = '0;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic set_pos(input int x, input int y);
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = 1'b1;
        tick;
        pos_valid = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic fill_rom(input logic [31:0] pat);
        for (int r = 0; r < 32; r++) rom[r] = pat;
    endtask

    // Drives one full line; pixel_on sampled after the strobe for column h
    // is the pixel for column h. With div=2 an idle cycle follows each strobe
    // and pixel_on must hold across it.
    task automatic run_line(input int v, input int div, output int first, output int last,
                            output int cnt, output int busy_seen, output int hold_err);
        logic p;
        first = -1; last = -1; cnt = 0; busy_seen = 0; hold_err = 0;
        vcount = 10'(v);
        for (int h = 0; h < H_TOTAL; h++) begin
            hcount = 10'(h);
            pix_en = 1'b1;
            tick;
            p = pixel_on;
            if (busy === 1'b1) busy_seen = 1;
            if (div > 1) begin
                pix_en = 1'b0;
                tick;
                if (pixel_on !== p) hold_err++;
                if (busy === 1'b1) busy_seen = 1;
            end
            if (p === 1'b1) begin
                if (first < 0) first = h;
                last = h;
                cnt++;
            end
        end
        pix_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f, l, c, b, h, prev;

        //          x    y    line  pattern        div fetch addr first last cnt
        vecs[0]  = '{100, 50,  50,  32'h0001F800, 1,  1,    0,   115,  120, 6};
        vecs[1]  = '{100, 50,  49,  32'hFFFFFFFF, 1,  0,    0,   -1,   -1,  0};
        vecs[2]  = '{100, 50,  81,  32'hFFFFFFFF, 1,  1,    31,  100,  131, 32};
        vecs[3]  = '{100, 50,  82,  32'hFFFFFFFF, 1,  0,    0,   -1,   -1,  0};
        vecs[4]  = '{50,  200, 200, 32'h80000001, 1,  1,    0,   50,   81,  2};
        vecs[5]  = '{50,  200, 231, 32'h80000001, 1,  1,    31,  50,   81,  2};
        vecs[6]  = '{50,  200, 232, 32'hFFFFFFFF, 1,  0,    0,   -1,   -1,  0};
        vecs[7]  = '{620, 10,  10,  32'hFFFFFFFF, 1,  1,    0,   620,  639, 20};
        vecs[8]  = '{608, 300, 300, 32'hFFFFFFFF, 1,  1,    0,   608,  639, 32};
        vecs[9]  = '{700, 100, 100, 32'hFFFFFFFF, 1,  1,    0,   -1,   -1,  0};
        vecs[10] = '{200, 524, 524, 32'h80000001, 1,  1,    0,   200,  231, 2};
        vecs[11] = '{200, 524, 0,   32'h40000000, 1,  1,    1,   201,  201, 1};
        vecs[12] = '{200, 524, 30,  32'h00000001, 1,  1,    31,  231,  231, 1};
        vecs[13] = '{200, 524, 31,  32'hFFFFFFFF, 1,  0,    0,   -1,   -1,  0};
        vecs[14] = '{10,  400, 410, 32'hAAAAAAAA, 2,  1,    10,  10,   40,  16};
        vecs[15] = '{300, 5,   5,   32'h00000000, 1,  1,    0,   -1,   -1,  0};
        vecs[16] = '{639, 20,  20,  32'hFFFFFFFF, 1,  1,    0,   639,  639, 1};

        // Reset values
        fill_rom(32'h0);
        do_reset;
        check("reset_pixel_on", int'(pixel_on), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pos_ready", int'(pos_ready), 1);
        check("reset_addRom", int'(addRom), 0);

        // Table-driven lines: prime with the previous line, then check the target line
        for (int i = 0; i < 17; i++) begin
            fill_rom(vecs[i].pat);
            do_reset;
            set_pos(vecs[i].x, vecs[i].y);
            prev = (vecs[i].line == 0) ? 524 : vecs[i].line - 1;
            run_line(prev, vecs[i].div, f, l, c, b, h);
            check($sformatf("v%0d_fetch", i), b, vecs[i].exp_fetch);
            check($sformatf("v%0d_addRom", i), int'(addRom), vecs[i].exp_addr);
            run_line(vecs[i].line, vecs[i].div, f, l, c, b, h);
            check($sformatf("v%0d_count", i), c, vecs[i].exp_cnt);
            check($sformatf("v%0d_first", i), f, vecs[i].exp_first);
            check($sformatf("v%0d_last", i), l, vecs[i].exp_last);
            check($sformatf("v%0d_hold", i), h, 0);
        end

        // Handshake: old position for frame N, new one after the next frame_start
        fill_rom(32'hFFFFFFFF);
        do_reset;
        pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
        tick;
        pos_valid = 1'b0;
        check("hs_ready_after_accept", int'(pos_ready), 0);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        check("hs_ready_after_commit", int'(pos_ready), 1);
        pos_valid = 1'b1; pos_x = 10'd300; pos_y = 10'd60;
        tick;
        check("hs_ready_low", int'(pos_ready), 0);
        pos_x = 10'd400; tick;
        pos_x = 10'd500; tick;
        pos_valid = 1'b0;
        check("hs_ready_still_low", int'(pos_ready), 0);
        run_line(49, 1, f, l, c, b, h);
        run_line(50, 1, f, l, c, b, h);
        check("hs_frameN_first", f, 100);
        check("hs_frameN_count", c, 32);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        check("hs_ready_after_commit2", int'(pos_ready), 1);
        run_line(59, 1, f, l, c, b, h);
        run_line(60, 1, f, l, c, b, h);
        check("hs_frameN1_first", f, 300);
        check("hs_frameN1_count", c, 32);

        // Reset in the middle of a draw
        do_reset;
        set_pos(100, 50);
        run_line(49, 1, f, l, c, b, h);
        vcount = 10'd50;
        for (int hc = 0; hc < 110; hc++) begin
            hcount = 10'(hc); pix_en = 1'b1;
            tick;
        end
        check("rst_mid_pre_on", int'(pixel_on), 1);
        hcount = 10'd110;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pixel_on", int'(pixel_on), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_pos_ready", int'(pos_ready), 1);
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        set_pos(100, 50);
        run_line(49, 1, f, l, c, b, h);
        run_line(50, 1, f, l, c, b, h);
        check("rst_after_first", f, 100);
        check("rst_after_count", c, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
